snitch_sb_mp: RTL and testbench
===============================

// Module: snitch_sb_mp
// PURPOSE
//  Multi-port FPU register scoreboard, successor of the single-port scoreboard. Tracks
//  in-flight destination register addresses in Depth entries. Accepts up to NumPush
//  allocations and NumPop one-hot releases per cycle, and answers NumTestAddrs hazard
//  queries. Optional same-cycle bypasses on the query path. Sits between FPU issue
//  (push/test) and FPU writeback (pop).
// PARAMETERS
//  AddrWidth     5  width of tracked register address
//  Depth         8  number of scoreboard entries (>=2)
//  NumPush       2  allocation ports per cycle (1..Depth)
//  NumPop        2  release ports per cycle
//  NumTestAddrs  3  hazard query ports
//  PushBypass    0  1: a push accepted this cycle is visible to test_present_o this cycle
//  PopBypass     1  1: an entry released this cycle is hidden from test_present_o this cycle
// PORTS
//  clk_i           in   1                    clock
//  rst_i           in   1                    async reset, active-high
//  push_addr_i     in   NumPush*AddrWidth    address to record, per push port
//  push_valid_i    in   NumPush              push request
//  push_ready_o    out  NumPush              free entry granted to this port
//  push_index_o    out  NumPush*Depth        one-hot granted entry (valid when ready)
//  pop_index_i     in   NumPop*Depth         one-hot (or multi-hot) entries to release
//  pop_valid_i     in   NumPop               release request
//  test_addr_i     in   NumTestAddrs*AddrWidth  query addresses
//  test_present_o  out  NumTestAddrs         address held by an occupied entry
//  usage_o         out  $clog2(Depth+1)      occupied entry count (registered)
//  full_o          out  1                    usage_o == Depth
//  empty_o         out  1                    usage_o == 0
//  err_o           out  3                    sticky: [0] pop of free entry, [1] push while
//                                            not ready, [2] usage counter/occupancy mismatch
//  err_clr_i       in   1                    clears err_o the next cycle
// BEHAVIOUR
//  - State: occ_q[Depth], addr_q[Depth][AddrWidth], usage_q, err_q. Async reset: occ_q=0,
//    usage_q=0, err_q=0, addr_q=0. Outputs at reset: ready = all 1, full_o=0, empty_o=1,
//    test_present_o=0, err_o=0.
//  - Allocation (combinational from occ_q only): free entries are ordered lowest index
//    first. Valid push ports are served in ascending port order. The k-th valid port gets
//    the k-th free entry. ready[p]=1 iff free count > number of valid ports below p. An
//    invalid port still reports ready/index as if it were the next requester. Same-cycle
//    pops never free an entry for a same-cycle push.
//  - Accepted push (valid&ready): next edge sets occ_q[idx]=1 and addr_q[idx]=addr. No
//    entry is granted to two ports.
//  - Pop: each set bit of a valid pop port clears occ_q next edge. Two pop ports naming the
//    same entry clear it once; no error. Popping a free entry sets err[0] and is ignored.
//    Pop and push never target the same entry in one cycle.
//  - Push with valid&!ready: dropped, sets err[1].
//  - usage_q += accepted pushes - effective pops (distinct, occupied entries) each cycle.
//    err[2] sets if usage_q != popcount(occ_q). full_o/empty_o derive from usage_q.
//  - test_present_o[j] = OR over i of occ_q[i] & addr_q[i]==test_addr_i[j]
//    & !(PopBypass & popped_i), OR (PushBypass & any accepted push with matching addr).
//    Duplicate addresses across entries are legal (WAW); present while any copy remains.
//  - Latency: push/pop affect usage/full/test 1 cycle later, except bypass terms (0 cycles).
//  - err_o bits are sticky until err_clr_i. A new error in the clear cycle wins.
//  - Reset mid-operation: all entries free immediately; in-flight pops after reset flag err[0].
// TESTING
//  1. Reset; push ports 0,1 valid addr 3,7 -> idx 0b0001,0b0010, ready=11; next cycle
//     usage=2, test(3)=1, test(7)=1.
//  2. Fill Depth=8 with 4 double-pushes -> full_o=1, ready=00. Pop idx 0b0100 plus push
//     addr 9 in the same cycle -> push refused (err[1]=1); next cycle ready[0]=1 with
//     idx 0b0100.
//  3. 7 entries used, both ports push -> port0 ready with last free idx, port1 ready=0.
//     If port0 is idle, port1 gets that entry.
//  4. Entries 0,1 both hold addr 5; pop 0 -> test(5)=1; pop 1 -> test(5)=0 same cycle
//     with PopBypass=1, next cycle with PopBypass=0.
//  5. Pop free entry 0b1000 -> err_o=001, occ unchanged. err_clr_i pulse -> err_o=000.
//  6. Both pop ports release entry 2 together -> usage decrements by 1, err_o=000.
//     Assert rst_i mid-burst -> usage=0 and ready all 1 asynchronously.

Source files
------------

// File: rtl/snitch_sb_mp.sv
// Multi-port FPU register scoreboard: tracks in-flight destination addresses,
// grants free entries to push ports in order and answers RAW/WAW hazard queries.
module snitch_sb_mp #(
  parameter int unsigned AddrWidth    = 5,
  parameter int unsigned Depth        = 8,
  parameter int unsigned NumPush      = 2,
  parameter int unsigned NumPop       = 2,
  parameter int unsigned NumTestAddrs = 3,
  parameter bit          PushBypass   = 1'b0,
  parameter bit          PopBypass    = 1'b1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumPush*AddrWidth-1:0]      push_addr_i,
  input  logic [NumPush-1:0]                push_valid_i,
  output logic [NumPush-1:0]                push_ready_o,
  output logic [NumPush*Depth-1:0]          push_index_o,
  input  logic [NumPop*Depth-1:0]           pop_index_i,
  input  logic [NumPop-1:0]                 pop_valid_i,
  input  logic [NumTestAddrs*AddrWidth-1:0] test_addr_i,
  output logic [NumTestAddrs-1:0]           test_present_o,
  output logic [$clog2(Depth+1)-1:0]        usage_o,
  output logic                              full_o,
  output logic                              empty_o,
  output logic [2:0]                        err_o,
  input  logic                              err_clr_i
);
  localparam int unsigned UW = $clog2(Depth+1);

  logic [Depth-1:0]                occ_q, occ_d;
  logic [Depth-1:0][AddrWidth-1:0] addr_q, addr_d;
  logic [UW-1:0]                   usage_q, usage_d;
  logic [2:0]                      err_q, err_d;
  logic [NumPush-1:0][Depth-1:0]   grant;
  logic [NumPush-1:0]              accept;
  logic [Depth-1:0]                pop_mask, pop_eff, push_set;

  // Port p is served by the free entry whose rank equals the number of valid ports below p.
  always_comb begin
    logic [UW-1:0] free_cnt, below, seen;
    free_cnt     = '0;
    grant        = '0;
    push_ready_o = '0;
    for (int unsigned i = 0; i < Depth; i++) free_cnt = free_cnt + UW'(~occ_q[i]);
    for (int unsigned p = 0; p < NumPush; p++) begin
      below = '0;
      for (int unsigned q = 0; q < p; q++) below = below + UW'(push_valid_i[q]);
      seen = '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        if (!occ_q[i]) begin
          if (seen == below) grant[p][i] = 1'b1;
          seen = seen + UW'(1);
        end
      end
      push_ready_o[p] = (free_cnt > below);
    end
  end

  assign push_index_o = grant;
  assign accept       = push_valid_i & push_ready_o;

  always_comb begin
    logic [UW-1:0] n_push, n_pop, n_occ;
    logic [2:0]    new_err;
    pop_mask = '0;
    push_set = '0;
    addr_d   = addr_q;
    n_push   = '0;
    n_pop    = '0;
    n_occ    = '0;
    for (int unsigned k = 0; k < NumPop; k++)
      if (pop_valid_i[k]) pop_mask = pop_mask | pop_index_i[k*Depth +: Depth];
    pop_eff = pop_mask & occ_q;
    for (int unsigned p = 0; p < NumPush; p++) begin
      if (accept[p]) begin
        push_set = push_set | grant[p];
        n_push   = n_push + UW'(1);
        for (int unsigned i = 0; i < Depth; i++)
          if (grant[p][i]) addr_d[i] = push_addr_i[p*AddrWidth +: AddrWidth];
      end
    end
    occ_d = (occ_q & ~pop_eff) | push_set;
    for (int unsigned i = 0; i < Depth; i++) begin
      n_pop = n_pop + UW'(pop_eff[i]);
      n_occ = n_occ + UW'(occ_q[i]);
    end
    usage_d = usage_q + n_push - n_pop;
    new_err = {usage_q != n_occ, |(push_valid_i & ~push_ready_o), |(pop_mask & ~occ_q)};
    err_d   = err_clr_i ? new_err : (err_q | new_err);
  end

  always_comb begin
    logic                 hit;
    logic [AddrWidth-1:0] ta;
    test_present_o = '0;
    for (int unsigned j = 0; j < NumTestAddrs; j++) begin
      hit = 1'b0;
      ta  = test_addr_i[j*AddrWidth +: AddrWidth];
      for (int unsigned i = 0; i < Depth; i++)
        if (occ_q[i] && (addr_q[i] == ta) && !(PopBypass && pop_eff[i])) hit = 1'b1;
      if (PushBypass) begin
        for (int unsigned p = 0; p < NumPush; p++)
          if (accept[p] && (push_addr_i[p*AddrWidth +: AddrWidth] == ta)) hit = 1'b1;
      end
      test_present_o[j] = hit;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q   <= '0;
      addr_q  <= '0;
      usage_q <= '0;
      err_q   <= '0;
    end else begin
      occ_q   <= occ_d;
      addr_q  <= addr_d;
      usage_q <= usage_d;
      err_q   <= err_d;
    end
  end

  assign usage_o = usage_q;
  assign full_o  = (usage_q == UW'(Depth));
  assign empty_o = (usage_q == '0);
  assign err_o   = err_q;
endmodule

// File: tb/tb_snitch_sb_mp.sv
// Scoreboard bench for snitch_sb_mp: stimulus queues expected values tagged with
// the cycle they are due; a negedge monitor pops and compares them.
module tb_snitch_sb_mp;
  localparam int K_RDY = 0, K_IDX = 1, K_USE = 2, K_FULL = 3, K_EMPTY = 4, K_TEST = 5, K_ERR = 6;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [9:0]  push_addr_i;
  logic [1:0]  push_valid_i;
  logic [1:0]  push_ready_o;
  logic [15:0] push_index_o;
  logic [15:0] pop_index_i;
  logic [1:0]  pop_valid_i;
  logic [14:0] test_addr_i;
  logic [2:0]  test_present_o;
  logic [3:0]  usage_o;
  logic        full_o, empty_o;
  logic [2:0]  err_o;
  logic        err_clr_i;

  snitch_sb_mp #(
    .AddrWidth(5), .Depth(8), .NumPush(2), .NumPop(2), .NumTestAddrs(3),
    .PushBypass(1'b0), .PopBypass(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .push_addr_i(push_addr_i), .push_valid_i(push_valid_i),
    .push_ready_o(push_ready_o), .push_index_o(push_index_o),
    .pop_index_i(pop_index_i), .pop_valid_i(pop_valid_i),
    .test_addr_i(test_addr_i), .test_present_o(test_present_o),
    .usage_o(usage_o), .full_o(full_o), .empty_o(empty_o),
    .err_o(err_o), .err_clr_i(err_clr_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      K_RDY:   return 32'(push_ready_o);
      K_IDX:   return 32'(push_index_o);
      K_USE:   return 32'(usage_o);
      K_FULL:  return 32'(full_o);
      K_EMPTY: return 32'(empty_o);
      K_TEST:  return 32'(test_present_o);
      default: return 32'(err_o);
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] a;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      a = actual(e.kind);
      n_cmp++;
      if (e.cyc != cyc || a !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %0h expected %0h (cycle %0d, due %0d)", e.name, a, e.exp, cyc, e.cyc);
      end
    end
  end

  task automatic chk(input int unsigned off, input string name, input int kind, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc + off; e.name = name; e.kind = kind; e.exp = v;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] pv, input int a0, input int a1,
                     input logic [1:0] popv, input int p0, input int p1, input logic clr);
    push_valid_i = pv;
    push_addr_i  = {5'(a1), 5'(a0)};
    pop_valid_i  = popv;
    pop_index_i  = {8'(p1), 8'(p0)};
    err_clr_i    = clr;
  endtask

  task automatic set_test(input int t0, input int t1, input int t2);
    test_addr_i = {5'(t2), 5'(t1), 5'(t0)};
  endtask

  initial begin
    rst_i = 1'b1;
    drv(2'b00, 0, 0, 2'b00, 0, 0, 1'b0);
    set_test(0, 0, 0);
    step(); step();
    rst_i = 1'b0;
    #1;
    n_cmp++;
    if (push_ready_o !== 2'b11) begin
      n_bad++;
      $display("FAIL d_rst_ready: got %0h expected 3", push_ready_o);
    end
    n_cmp++;
    if (usage_o !== 4'd0) begin
      n_bad++;
      $display("FAIL d_rst_usage: got %0h expected 0", usage_o);
    end
    n_cmp++;
    if (full_o !== 1'b0) begin
      n_bad++;
      $display("FAIL d_rst_full: got %0h expected 0", full_o);
    end
    n_cmp++;
    if (empty_o !== 1'b1) begin
      n_bad++;
      $display("FAIL d_rst_empty: got %0h expected 1", empty_o);
    end
    n_cmp++;
    if (err_o !== 3'b000) begin
      n_bad++;
      $display("FAIL d_rst_err: got %0h expected 0", err_o);
    end
    chk(0, "rst_ready", K_RDY, 3);
    chk(0, "rst_idx", K_IDX, 16'h0101);
    chk(0, "rst_usage", K_USE, 0);
    chk(0, "rst_full", K_FULL, 0);
    chk(0, "rst_empty", K_EMPTY, 1);
    chk(0, "rst_test", K_TEST, 0);
    chk(0, "rst_err", K_ERR, 0);
    step();

    // 1: double push into an empty board
    set_test(3, 7, 0);
    drv(2'b11, 3, 7, 2'b00, 0, 0, 1'b0);
    chk(0, "t1_ready", K_RDY, 3);
    chk(0, "t1_idx", K_IDX, 16'h0201);
    chk(0, "t1_test_nobyp", K_TEST, 0);
    chk(1, "t1_usage", K_USE, 2);
    chk(1, "t1_test", K_TEST, 3'b011);
    chk(1, "t1_empty", K_EMPTY, 0);
    step();
    n_cmp++;
    if (usage_o !== 4'd2) begin
      n_bad++;
      $display("FAIL d_t1_usage: got %0h expected 2", usage_o);
    end
    n_cmp++;
    if (test_present_o !== 3'b011) begin
      n_bad++;
      $display("FAIL d_t1_test: got %0h expected 3", test_present_o);
    end

    // 2: fill, then pop entry 2 while a refused push arrives
    drv(2'b11, 10, 11, 2'b00, 0, 0, 1'b0); step();
    drv(2'b11, 12, 13, 2'b00, 0, 0, 1'b0); step();
    drv(2'b11, 14, 15, 2'b00, 0, 0, 1'b0);
    chk(1, "t2_full", K_FULL, 1);
    chk(1, "t2_ready_full", K_RDY, 0);
    chk(1, "t2_usage8", K_USE, 8);
    step();
    set_test(10, 9, 3);
    drv(2'b01, 9, 0, 2'b01, 8'h04, 0, 1'b0);
    chk(0, "t2_pop_bypass", K_TEST, 3'b100);
    chk(0, "t2_ready_refused", K_RDY, 0);
    chk(1, "t2_err_refused", K_ERR, 3'b010);
    chk(1, "t2_ready_after_pop", K_RDY, 3);
    chk(1, "t2_idx_after_pop", K_IDX, 16'h0404);
    chk(1, "t2_usage7", K_USE, 7);
    step();

    // 3: last free entry goes to the lowest valid port
    set_test(21, 10, 3);
    drv(2'b10, 0, 21, 2'b00, 0, 0, 1'b1);
    chk(1, "t3_full", K_FULL, 1);
    chk(1, "t3_err_cleared", K_ERR, 0);
    step();
    drv(2'b00, 0, 0, 2'b00, 0, 0, 1'b0);
    chk(0, "t3_test21", K_TEST, 3'b101);
    step();
    drv(2'b00, 0, 0, 2'b10, 0, 8'h04, 1'b0);
    chk(0, "t3_pop_hide", K_TEST, 3'b100);
    chk(1, "t3_usage7", K_USE, 7);
    step();
    set_test(20, 22, 3);
    drv(2'b11, 20, 22, 2'b00, 0, 0, 1'b0);
    chk(0, "t3_ready_one", K_RDY, 2'b01);
    chk(0, "t3_idx_last", K_IDX, 16'h0004);
    chk(1, "t3_err_refused", K_ERR, 3'b010);
    chk(1, "t3_full2", K_FULL, 1);
    chk(1, "t3_test20", K_TEST, 3'b101);
    step();
    drv(2'b00, 0, 0, 2'b00, 0, 0, 1'b1);
    chk(1, "t3_err_clr", K_ERR, 0);
    step();

    // 4: duplicate address in two entries
    drv(2'b00, 0, 0, 2'b01, 8'hFF, 0, 1'b0);
    chk(1, "t4_empty", K_EMPTY, 1);
    chk(1, "t4_usage0", K_USE, 0);
    chk(1, "t4_err_none", K_ERR, 0);
    step();
    set_test(5, 0, 0);
    drv(2'b11, 5, 5, 2'b00, 0, 0, 1'b0);
    chk(1, "t4_test5", K_TEST, 3'b001);
    chk(1, "t4_usage2", K_USE, 2);
    step();
    drv(2'b00, 0, 0, 2'b01, 8'h01, 0, 1'b0);
    chk(0, "t4_pop0_still", K_TEST, 3'b001);
    step();
    drv(2'b00, 0, 0, 2'b01, 8'h02, 0, 1'b0);
    chk(0, "t4_pop1_hidden", K_TEST, 0);
    chk(1, "t4_usage_zero", K_USE, 0);
    step();

    // 5: pop of a free entry, sticky error and clear priority
    drv(2'b00, 0, 0, 2'b01, 8'h08, 0, 1'b0);
    chk(1, "t5_err_pop_free", K_ERR, 3'b001);
    chk(1, "t5_usage_same", K_USE, 0);
    step();
    drv(2'b00, 0, 0, 2'b01, 8'h08, 0, 1'b1);
    chk(1, "t5_err_new_wins", K_ERR, 3'b001);
    step();
    drv(2'b00, 0, 0, 2'b00, 0, 0, 1'b1);
    chk(1, "t5_err_cleared", K_ERR, 0);
    step();

    // 6: both pop ports on one entry, then reset mid-burst
    drv(2'b11, 1, 2, 2'b00, 0, 0, 1'b0); step();
    drv(2'b11, 3, 4, 2'b00, 0, 0, 1'b0);
    chk(1, "t6_usage4", K_USE, 4);
    step();
    drv(2'b00, 0, 0, 2'b11, 8'h04, 8'h04, 1'b0);
    chk(1, "t6_usage3", K_USE, 3);
    chk(1, "t6_err_none", K_ERR, 0);
    step();
    drv(2'b00, 0, 0, 2'b00, 0, 0, 1'b0);
    step();
    set_test(1, 2, 4);
    drv(2'b11, 8, 9, 2'b00, 0, 0, 1'b0);
    rst_i = 1'b1;
    chk(0, "t6_rst_usage", K_USE, 0);
    chk(0, "t6_rst_ready", K_RDY, 3);
    chk(0, "t6_rst_empty", K_EMPTY, 1);
    chk(0, "t6_rst_test", K_TEST, 0);
    chk(0, "t6_rst_idx", K_IDX, 16'h0201);
    step();
    rst_i = 1'b0;
    drv(2'b00, 0, 0, 2'b01, 8'h01, 0, 1'b0);
    chk(1, "t6_err_stale_pop", K_ERR, 3'b001);
    chk(1, "t6_usage_after", K_USE, 0);
    step();
    drv(2'b00, 0, 0, 2'b00, 0, 0, 1'b0);
    step();

    repeat (4) @(negedge clk);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no sample expected %0h (due cycle %0d)", e.name, e.exp, e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
